// File: rtl/wdq_sequencer.sv
// rtl/wdq_sequencer.sv - DDR2 write-data sequencer: buffers write data and launches ODDR beat pairs at write latency
// Optional feature macro: WDQ_ERRCHECK_EN (sticky ErrFlags {spacing, underflow, overflow}; tied to 0 when undefined)
module wdq_sequencer #(
   parameter int DQ_WIDTH  = 64,
   parameter int DEPTH     = 8,
   parameter int WR_LAT    = 3,
   parameter int BURST_CYC = 2
) (
   input  logic                    MCLK90,
   input  logic                    ResetN,
   input  logic [2*DQ_WIDTH-1:0]   WdIn,
   input  logic                    WdValid,
   output logic                    WdReady,
   input  logic                    WriteCmd,
   output logic [DQ_WIDTH-1:0]     WbufQ0,
   output logic [DQ_WIDTH-1:0]     WbufQ1,
   output logic                    ReadWB,
   output logic                    DqsEn,
   output logic [$clog2(DEPTH):0]  Level,
   output logic [2:0]              ErrFlags
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int PL = (WR_LAT > 1) ? WR_LAT - 1 : 1;
   localparam int PT = (WR_LAT > 1) ? WR_LAT - 2 : 0;
   localparam int CW = (BURST_CYC > 1) ? $clog2(BURST_CYC) : 1;
   localparam int RW = $clog2(BURST_CYC + 1);
   localparam logic [LW-1:0] FULL = LW'(DEPTH);
   localparam logic [LW-1:0] BC_L = LW'(BURST_CYC);
   localparam logic [CW-1:0] LAST = CW'(BURST_CYC - 1);
   localparam logic [RW-1:0] BC_R = RW'(BURST_CYC);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   logic [2*DQ_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]         level_q;
   logic [PL-1:0]         pipe_q;
   logic [RW-1:0]         since_q;
   state_t                state_q;
   logic [CW-1:0]         cnt_q;
   logic [RW-1:0]         rem_q;
   logic [DQ_WIDTH-1:0]   q0_q, q1_q;
   logic                  readwb_q, dqs_q;

   logic                  push, pop, cmd_ok, start_tap, pre_tap;
   logic                  last_beat, new_burst, beat_next;
   logic [PL:0]           sr;
   logic [RW-1:0]         avail, src, rem_d;
   logic [2*DQ_WIDTH-1:0] rd_data;

   assign WdReady   = (level_q != FULL);
   assign push      = WdValid & WdReady;
   // Commands closer than one burst to the last accepted one never enter the pipeline.
   assign cmd_ok    = WriteCmd & (since_q >= BC_R);
   // sr[0] is the command cycle itself, sr[k] the command k cycles ago.
   assign sr        = {pipe_q, cmd_ok};
   assign start_tap = sr[WR_LAT-1];
   assign pre_tap   = (WR_LAT > 1) ? sr[PT] : 1'b0;

   assign last_beat = (state_q == S_BURST) && (cnt_q == LAST);
   assign new_burst = start_tap & ((state_q == S_IDLE) | last_beat);
   assign beat_next = new_burst | ((state_q == S_BURST) & ~last_beat);

   // Entries that exist at burst start bound the pops; missing beats go out as zero.
   assign avail     = (level_q < BC_L) ? RW'(level_q) : BC_R;
   assign src       = new_burst ? avail : rem_q;
   assign pop       = beat_next & (src != '0);
   assign rem_d     = beat_next ? (src - RW'(pop)) : '0;
   assign rd_data   = mem_q[rd_ptr_q];

   assign WbufQ0    = q0_q;
   assign WbufQ1    = q1_q;
   assign ReadWB    = readwb_q;
   // With WR_LAT=1 the preamble is the command cycle, so it cannot come from a register.
   assign DqsEn     = dqs_q | ((WR_LAT == 1) && cmd_ok);
   assign Level     = level_q;

   // Storage array: written on accepted pushes, no reset needed.
   always_ff @(posedge MCLK90) begin
      if (push) mem_q[wr_ptr_q] <= WdIn;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge MCLK90 or negedge ResetN) begin
      if (!ResetN) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_q + LW'(push) - LW'(pop);
      end
   end

   // Launch pipeline and command-spacing counter.
   always_ff @(posedge MCLK90 or negedge ResetN) begin
      if (!ResetN) begin
         pipe_q  <= '0;
         since_q <= BC_R;
      end else begin
         pipe_q <= sr[PL-1:0];
         if (cmd_ok)               since_q <= RW'(1);
         else if (since_q < BC_R)  since_q <= since_q + 1'b1;
      end
   end

   // Burst state machine with registered beat, ReadWB and DqsEn outputs.
   always_ff @(posedge MCLK90 or negedge ResetN) begin
      if (!ResetN) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         q0_q     <= '0;
         q1_q     <= '0;
         readwb_q <= 1'b0;
         dqs_q    <= 1'b0;
      end else begin
         rem_q    <= rem_d;
         readwb_q <= beat_next;
         dqs_q    <= beat_next | pre_tap;
         q0_q     <= pop ? rd_data[DQ_WIDTH-1:0] : '0;
         q1_q     <= pop ? rd_data[2*DQ_WIDTH-1:DQ_WIDTH] : '0;
         case (state_q)
            S_IDLE: begin
               if (start_tap) begin
                  state_q <= S_BURST;
                  cnt_q   <= '0;
               end
            end
            default: begin
               if (last_beat) begin
                  cnt_q <= '0;
                  if (!start_tap) state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
         endcase
      end
   end

`ifdef WDQ_ERRCHECK_EN
   logic [2:0] err_q;

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge MCLK90 or negedge ResetN) begin
      if (!ResetN) begin
         err_q <= '0;
      end else begin
         err_q <= err_q | {WriteCmd & ~cmd_ok,
                           new_burst & (level_q < BC_L),
                           WdValid & ~WdReady};
      end
   end

   assign ErrFlags = err_q;
`else
   assign ErrFlags = 3'b000;
`endif

endmodule

// File: tb/tb_wdq_sequencer.sv
// tb/tb_wdq_sequencer.sv - scoreboard testbench for wdq_sequencer with queue-based reference model
module tb_wdq_sequencer;
   localparam int DQ     = 64;
   localparam int DEPTH  = 8;
   localparam int WR_LAT = 3;
   localparam int BC     = 2;
   localparam int NCYC   = 4096;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic [2*DQ-1:0] wd_in = '0;
   logic            wd_valid = 1'b0;
   logic            wd_ready;
   logic            write_cmd = 1'b0;
   logic [DQ-1:0]   q0, q1;
   logic            readwb, dqs_en;
   logic [3:0]      level;
   logic [2:0]      err_flags;

   wdq_sequencer #(.DQ_WIDTH(DQ), .DEPTH(DEPTH), .WR_LAT(WR_LAT), .BURST_CYC(BC)) dut (
      .MCLK90(clk), .ResetN(rstn), .WdIn(wd_in), .WdValid(wd_valid), .WdReady(wd_ready),
      .WriteCmd(write_cmd), .WbufQ0(q0), .WbufQ1(q1), .ReadWB(readwb), .DqsEn(dqs_en),
      .Level(level), .ErrFlags(err_flags)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            c;
      logic [DQ-1:0] d0;
      logic [DQ-1:0] d1;
   } beat_t;

   logic [2*DQ-1:0] mq[$];
   beat_t           sb[$];
   int              pop_due[$];
   int              start_due[$];
   bit              dqs_exp[NCYC];
   int              last_acc = -100;
   logic [2:0]      err_m = '0;
   bit              mon_en = 1'b0;
   int              n_chk = 0;
   int              n_fail = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [2:0] ef_exp();
`ifdef WDQ_ERRCHECK_EN
      return err_m;
`else
      return 3'b000;
`endif
   endfunction

   task automatic model_clear();
      mq.delete(); sb.delete(); pop_due.delete(); start_due.delete();
      for (int i = 0; i < NCYC; i++) dqs_exp[i] = 1'b0;
      last_acc = -100;
      err_m = '0;
   endtask

   // Effects of this cycle's inputs, as seen at the next rising edge.
   task automatic model_cycle(input bit v, input logic [2*DQ-1:0] d, input bit cmd);
      int  now;
      bit  rdy;
      now = cyc;
      rdy = (mq.size() != DEPTH);
      if (start_due.size() != 0 && start_due[0] == now) begin
         int k;
         void'(start_due.pop_front());
         k = (mq.size() < BC) ? mq.size() : BC;
         if (mq.size() < BC) err_m[1] = 1'b1;
         for (int b = 0; b < BC; b++) begin
            beat_t bt;
            logic [2*DQ-1:0] e;
            e = (b < k) ? mq[b] : '0;
            bt.c = now + 1 + b; bt.d0 = e[DQ-1:0]; bt.d1 = e[2*DQ-1:DQ];
            sb.push_back(bt);
            if (b < k) pop_due.push_back(now + b);
         end
      end
      if (pop_due.size() != 0 && pop_due[0] == now) begin
         void'(pop_due.pop_front());
         void'(mq.pop_front());
      end
      if (v) begin
         if (rdy) mq.push_back(d);
         else err_m[0] = 1'b1;
      end
      if (cmd) begin
         if (now - last_acc >= BC) begin
            last_acc = now;
            start_due.push_back(now + WR_LAT - 1);
            for (int x = now + WR_LAT - 1; x <= now + WR_LAT + BC - 1; x++)
               if (x < NCYC) dqs_exp[x] = 1'b1;
         end else begin
            err_m[2] = 1'b1;
         end
      end
   endtask

   task automatic step(input bit v, input logic [2*DQ-1:0] d, input bit cmd);
      @(negedge clk);
      chk("level", level, mq.size());
      chk("wdready", wd_ready, (mq.size() != DEPTH));
      chk("errflags", err_flags, ef_exp());
      wd_valid = v; wd_in = d; write_cmd = cmd;
      model_cycle(v, d, cmd);
   endtask

   function automatic logic [2*DQ-1:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
   endtask

   // Monitor: pops expected beats whenever the DUT drives a burst beat.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("dqsen", dqs_en, (cyc < NCYC) ? dqs_exp[cyc] : 1'b0);
         if (readwb) begin
            if (sb.size() == 0) begin
               chk("readwb_unexpected", readwb, 1'b0);
            end else begin
               beat_t b;
               b = sb.pop_front();
               chk("beat_cycle", cyc, b.c);
               chk("wbufq0", q0, b.d0);
               chk("wbufq1", q1, b.d1);
            end
         end else begin
            chk("wbufq0_idle", q0, '0);
            chk("wbufq1_idle", q1, '0);
            if (sb.size() != 0 && sb[0].c <= cyc) begin
               chk("readwb_missing", readwb, 1'b1);
               void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      int t;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_level", level, 0);
      chk("rst_wdready", wd_ready, 1);
      chk("rst_readwb", readwb, 0);
      chk("rst_dqsen", dqs_en, 0);
      chk("rst_q0", q0, 0);
      chk("rst_q1", q1, 0);
      chk("rst_err", err_flags, 0);
      @(negedge clk);
      rstn = 1'b1;
      mon_en = 1'b1;
      idle(3);

      // Single write
      step(1'b1, rnd(), 1'b0);
      step(1'b1, rnd(), 1'b0);
      idle(2);
      step(1'b0, '0, 1'b1);
      idle(8);

      // Back-to-back bursts
      for (int i = 0; i < 4; i++) step(1'b1, rnd(), 1'b0);
      step(1'b0, '0, 1'b1);
      idle(1);
      step(1'b0, '0, 1'b1);
      idle(8);

      // Fill, overflow, then bursts interleaved with pushes across the wrap
      for (int i = 0; i < DEPTH + 1; i++) step(1'b1, rnd(), 1'b0);
      idle(1);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, '0, 1'b1);
         step(1'b1, rnd(), 1'b0);
         step(1'b1, rnd(), 1'b0);
         idle(2);
      end
      t = 0;
      while (mq.size() != 0 && t < 20) begin
         step(1'b0, '0, 1'b1);
         idle(BC + WR_LAT);
         t++;
      end
      idle(4);

      // Underflow: one entry for a two-beat burst
      step(1'b1, rnd(), 1'b0);
      step(1'b0, '0, 1'b1);
      idle(8);

      // Spacing violation
      step(1'b1, rnd(), 1'b0);
      step(1'b1, rnd(), 1'b0);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      idle(8);

      // Reset during the second beat of a burst
      step(1'b1, rnd(), 1'b0);
      step(1'b1, rnd(), 1'b0);
      step(1'b0, '0, 1'b1);
      t = 0;
      while (readwb !== 1'b1 && t < 20) begin
         step(1'b0, '0, 1'b0);
         t++;
      end
      @(posedge clk);
      #2;
      chk("pre_reset_readwb", readwb, 1);
      mon_en = 1'b0;
      rstn = 1'b0;
      #1;
      chk("mid_rst_readwb", readwb, 0);
      chk("mid_rst_dqsen", dqs_en, 0);
      chk("mid_rst_q0", q0, 0);
      chk("mid_rst_q1", q1, 0);
      model_clear();
      @(negedge clk);
      rstn = 1'b1;
      mon_en = 1'b1;
      idle(3);

      // Randomized traffic
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 1) == 1), rnd(), ($urandom_range(0, 4) == 0));
      idle(12);
      chk("scoreboard_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
